// File: rtl/sum_accumulator.sv
// sum_accumulator: accumulates N carry-extended 32-bit adder results into a
// wide register, flags wrap-around, and holds the total until it is consumed.
module sum_accumulator #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [31:0]      in_sum,
  input  logic             in_carry,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic               ovf_q, ovf_d;

  // One extra bit on the left catches the carry out of the accumulator.
  logic [ACC_W:0]     sum_ext;
  logic               accept;

  assign accept  = in_valid && (state_q == ACCUM);
  assign sum_ext = {1'b0, acc_q} + {{(ACC_W-32){1'b0}}, in_carry, in_sum};

  // Next-state and datapath update for the three-state controller.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start && (num_samples != '0)) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          n_d     = num_samples;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        // Abort wins over a simultaneous sample; that sample is dropped.
        if (abort) begin
          state_d = IDLE;
        end else if (accept) begin
          acc_d = sum_ext[ACC_W-1:0];
          cnt_d = cnt_q + 1'b1;
          if (sum_ext[ACC_W]) ovf_d = 1'b1;
          if (cnt_q + 1'b1 == n_q) state_d = HOLD;
        end
      end
      HOLD: begin
        // Start is deliberately ignored here; it must be re-issued in IDLE.
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs decode straight from registered state, so they are glitch-free.
  assign in_ready   = (state_q == ACCUM);
  assign out_valid  = (state_q == HOLD);
  assign busy       = (state_q != IDLE);
  assign acc_out    = acc_q;
  assign sample_cnt = cnt_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed self-checking bench for sum_accumulator.
module tb_sum_accumulator;

  localparam int ACC_W = 40;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic             abort;
  logic             in_valid;
  logic [31:0]      in_sum;
  logic             in_carry;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic [CNT_W-1:0] sample_cnt;
  logic             overflow;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  sum_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_samples(num_samples),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_sum     (in_sum),
    .in_carry   (in_carry),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .acc_out    (acc_out),
    .sample_cnt (sample_cnt),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [CNT_W-1:0] n);
    start = 1'b1;
    num_samples = n;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] s, input logic c);
    in_valid = 1'b1;
    in_sum   = s;
    in_carry = c;
    step();
    in_valid = 1'b0;
  endtask

  task automatic release_hold();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_samples = '0; abort = 1'b0;
    in_valid = 1'b0; in_sum = '0; in_carry = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_acc",   acc_out, 0);
    check("rst_busy",  busy, 0);
    check("rst_ready", in_ready, 0);
    @(negedge clk); rst_n = 1'b1;
    step();

    // Zero-length start is ignored.
    do_start(8'd0);
    check("n0_busy", busy, 0);

    // Basic: 5 + 10 with N=2.
    do_start(8'd2);
    check("basic_busy",  busy, 1);
    check("basic_ready", in_ready, 1);
    check("basic_cnt0",  sample_cnt, 0);
    send(32'h5, 1'b0);
    check("basic_acc1",  acc_out, 64'h5);
    check("basic_ov1",   out_valid, 0);
    send(32'hA, 1'b0);
    check("basic_acc2",  acc_out, 64'hF);
    check("basic_cnt2",  sample_cnt, 2);
    check("basic_ov2",   out_valid, 1);
    release_hold();
    check("basic_idle_ov",  out_valid, 0);
    check("basic_idle_acc", acc_out, 64'hF);

    // Carry word, then backpressure in HOLD with changing input data.
    do_start(8'd1);
    send(32'hFFFF_FFFF, 1'b1);
    check("carry_acc", acc_out, 64'h01_FFFF_FFFF);
    check("carry_ovf", overflow, 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_sum   = 32'h100 + i;
      in_carry = i[0];
      start    = 1'b1;
      num_samples = 8'd3;
      step();
      check("bp_ov",    out_valid, 1);
      check("bp_acc",   acc_out, 64'h01_FFFF_FFFF);
      check("bp_cnt",   sample_cnt, 1);
      check("bp_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    // start together with out_ready in HOLD must not relaunch.
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    start = 1'b0;
    check("bp_idle_ov",   out_valid, 0);
    check("bp_idle_busy", busy, 0);

    // Overflow: 255 samples of 0x1_FFFF_FFFF.
    do_start(8'd255);
    in_valid = 1'b1; in_sum = 32'hFFFF_FFFF; in_carry = 1'b1;
    for (int i = 0; i < 255; i++) step();
    in_valid = 1'b0;
    check("ovf_acc", acc_out, 64'hFD_FFFF_FF01);
    check("ovf_flag", overflow, 1);
    check("ovf_cnt", sample_cnt, 255);
    check("ovf_ov", out_valid, 1);
    abort = 1'b1; step(); abort = 1'b0;
    check("hold_abort_ov", out_valid, 1);
    release_hold();
    check("ovf_idle_flag", overflow, 1);
    do_start(8'd1);
    check("ovf_clear", overflow, 0);
    check("ovf_acc0", acc_out, 0);
    send(32'h1, 1'b0);
    release_hold();

    // Abort with a simultaneous valid sample.
    do_start(8'd3);
    send(32'h7, 1'b0);
    abort = 1'b1; in_valid = 1'b1; in_sum = 32'h9; in_carry = 1'b0;
    step();
    abort = 1'b0; in_valid = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_cnt",  sample_cnt, 1);
    check("abort_acc",  acc_out, 64'h7);
    check("abort_ov",   out_valid, 0);
    step();
    check("abort_ov2",  out_valid, 0);
    abort = 1'b1; step(); abort = 1'b0;
    check("idle_abort_busy", busy, 0);
    do_start(8'd2);
    check("abort_new_acc", acc_out, 0);
    check("abort_new_cnt", sample_cnt, 0);

    // Reset between edges in ACCUM.
    send(32'h33, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("mrst_acc",   acc_out, 0);
    check("mrst_cnt",   sample_cnt, 0);
    check("mrst_ovf",   overflow, 0);
    check("mrst_ov",    out_valid, 0);
    check("mrst_ready", in_ready, 0);
    check("mrst_busy",  busy, 0);
    step();
    @(negedge clk); rst_n = 1'b1;
    in_valid = 1'b1; in_sum = 32'h44;
    step(); step();
    in_valid = 1'b0;
    check("post_rst_busy", busy, 0);
    check("post_rst_acc",  acc_out, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
